// File: rtl/instruction_fetch_if.sv
// Bundle of the IF stage's pipeline-side and debug-side signals.
//   master : the side that drives the stage (ID redirect, hazard unit,
//            debug unit) and reads back the IF/ID register and PC.
//   slave  : the instruction_fetch stage itself.
// Signals:
//   i_jump / i_jump_addr : taken jump/branch and its target, from ID
//   i_stall              : load-use stall from the hazard detector
//   i_halt               : freezes the stage, enables program load
//   i_load_start/valid/byte : debug program-load byte stream (MSB first)
//   o_instruction/o_pc4  : IF/ID register
//   o_pc                 : current PC
//   o_load_count         : complete words written since last load start
interface instruction_fetch_if #(
    parameter int NB_DATA  = 32,
    parameter int NB_WADDR = 8
);
    logic                jump_unused_guard;
    logic                i_jump;
    logic [NB_DATA-1:0]  i_jump_addr;
    logic                i_stall;
    logic                i_halt;
    logic                i_load_start;
    logic                i_load_valid;
    logic [7:0]          i_load_byte;
    logic [NB_DATA-1:0]  o_instruction;
    logic [NB_DATA-1:0]  o_pc4;
    logic [NB_DATA-1:0]  o_pc;
    logic [NB_WADDR:0]   o_load_count;

    modport master (
        output i_jump, i_jump_addr, i_stall, i_halt,
               i_load_start, i_load_valid, i_load_byte,
        input  o_instruction, o_pc4, o_pc, o_load_count
    );

    modport slave (
        input  i_jump, i_jump_addr, i_stall, i_halt,
               i_load_start, i_load_valid, i_load_byte,
        output o_instruction, o_pc4, o_pc, o_load_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF pipeline stage plus IF/ID register.
// Holds the PC and the instruction memory. Fetch reads are registered
// (one-cycle latency). Priority per edge: reset, halt, stall, jump, advance.
// While halted, the debug unit can stream bytes in (MSB first); every 4th
// byte writes one word at an auto-incrementing word pointer.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset (memory contents survive it)
//   bus     : instruction_fetch_if slave modport (see interface header)
module instruction_fetch #(
    parameter int NB_DATA   = 32,
    parameter int MEM_WORDS = 256,
    parameter int NB_WADDR  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    instruction_fetch_if.slave bus
);
    localparam logic [NB_WADDR:0] CNT_MAX = (NB_WADDR+1)'(MEM_WORDS);

    logic [NB_DATA-1:0]  mem [MEM_WORDS];
    logic [NB_DATA-1:0]  pc;
    logic [NB_DATA-1:0]  instruction;
    logic [NB_DATA-1:0]  pc4;
    logic [23:0]         assembly;     // only the 3 older bytes are needed
    logic [1:0]          byte_cnt;
    logic [NB_WADDR-1:0] wptr;
    logic [NB_WADDR:0]   load_count;

    logic                load_en;
    logic                word_done;
    logic [NB_WADDR-1:0] raddr;

    // Load path is only live while halted; a start pulse drops a same-cycle byte.
    assign load_en   = bus.i_halt && !bus.i_load_start && bus.i_load_valid;
    assign word_done = load_en && (byte_cnt == 2'd3);
    assign raddr     = pc[NB_WADDR+1:2];

    // PC and IF/ID register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc          <= '0;
            instruction <= '0;
            pc4         <= '0;
        end else if (bus.i_halt || bus.i_stall) begin
            pc          <= pc;
            instruction <= instruction;
            pc4         <= pc4;
        end else if (bus.i_jump) begin
            // flush the wrong-path word: no delay slot
            pc          <= bus.i_jump_addr;
            instruction <= '0;
            pc4         <= '0;
        end else begin
            pc          <= pc + NB_DATA'(4);
            instruction <= mem[raddr];
            pc4         <= pc + NB_DATA'(4);
        end
    end

    // Program-load byte assembly and bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            assembly   <= '0;
            byte_cnt   <= '0;
            wptr       <= '0;
            load_count <= '0;
        end else if (bus.i_halt && bus.i_load_start) begin
            assembly   <= '0;
            byte_cnt   <= '0;
            wptr       <= '0;
            load_count <= '0;
        end else if (load_en) begin
            assembly <= {assembly[15:0], bus.i_load_byte};
            byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
            if (word_done) begin
                wptr <= wptr + NB_WADDR'(1);
                if (load_count != CNT_MAX)
                    load_count <= load_count + (NB_WADDR+1)'(1);
            end
        end
    end

    // Memory array has no reset so a loaded program survives i_reset.
    // The registered read above sees the pre-write value (read-before-write).
    always_ff @(posedge i_clk) begin
        if (!i_reset && word_done)
            mem[wptr] <= {assembly, bus.i_load_byte};
    end

    assign bus.o_instruction = instruction;
    assign bus.o_pc4         = pc4;
    assign bus.o_pc          = pc;
    assign bus.o_load_count  = load_count;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if #(.NB_DATA(32), .NB_WADDR(8)) bus ();

    instruction_fetch #(.NB_DATA(32), .MEM_WORDS(256), .NB_WADDR(8)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [8:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: program memory as an array, pending bytes as a queue.
    logic [31:0] m_mem [256];
    logic [7:0]  m_part[$];
    logic [31:0] m_pc, m_instr, m_pc4;
    int          m_wptr, m_cnt;

    task automatic model(input logic r, jmp, input logic [31:0] ja,
                         input logic stl, hlt, ls, lv, input logic [7:0] lb);
        if (r) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0;
            m_part.delete(); m_wptr = 0; m_cnt = 0;
            return;
        end
        if (hlt) begin
            if (ls) begin
                m_part.delete(); m_wptr = 0; m_cnt = 0;
            end else if (lv) begin
                m_part.push_back(lb);
                if (m_part.size() == 4) begin
                    m_mem[m_wptr] = {m_part[0], m_part[1], m_part[2], m_part[3]};
                    m_part.delete();
                    m_wptr = (m_wptr + 1) % 256;
                    if (m_cnt < 256) m_cnt++;
                end
            end
        end else if (stl) begin
            // hold
        end else if (jmp) begin
            m_pc = ja; m_instr = 0; m_pc4 = 0;
        end else begin
            m_instr = m_mem[(m_pc / 4) % 256];
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, jmp, input logic [31:0] ja,
                        input logic stl, hlt, ls, lv, input logic [7:0] lb);
        exp_t e;
        rst = r;
        bus.i_jump = jmp; bus.i_jump_addr = ja; bus.i_stall = stl;
        bus.i_halt = hlt; bus.i_load_start = ls; bus.i_load_valid = lv;
        bus.i_load_byte = lb;
        @(posedge clk);
        model(r, jmp, ja, stl, hlt, ls, lv, lb);
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = 9'(m_cnt);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] b);
        step(0, 0, 0, 0, 1, 0, 1, b);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: every cycle's registered outputs are compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (bus.o_pc !== e.pc) begin
                    bad++; $display("FAIL pc: got %h want %h @%0t", bus.o_pc, e.pc, $time);
                end
                if (bus.o_instruction !== e.instr) begin
                    bad++; $display("FAIL instruction: got %h want %h @%0t", bus.o_instruction, e.instr, $time);
                end
                if (bus.o_pc4 !== e.pc4) begin
                    bad++; $display("FAIL pc4: got %h want %h @%0t", bus.o_pc4, e.pc4, $time);
                end
                if (bus.o_load_count !== e.cnt) begin
                    bad++; $display("FAIL load_count: got %0d want %0d @%0t", bus.o_load_count, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] plan [8];
        logic [7:0] abcd [4];
        int r;
        logic [31:0] ja;
        plan = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        abcd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // Fill whole memory and overrun by 2 words: count saturates, pointer wraps
        for (int w = 0; w < 258 * 4; w++) load_byte(8'($urandom));

        // Restart mid-word; a byte alongside the start pulse is dropped
        step(0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) load_byte(8'($urandom));
        step(0, 0, 0, 0, 1, 1, 1, 8'h77);
        for (int i = 0; i < 4; i++) load_byte(abcd[i]);

        // Bytes while running are ignored
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, 8'($urandom));

        // Program load for the run, then a partial word cleared by reset
        step(0, 0, 0, 0, 1, 1, 0, 0);
        foreach (plan[i]) load_byte(plan[i]);
        load_byte(8'h55); load_byte(8'h66);
        step(1, 0, 0, 0, 1, 0, 0, 0);

        // Free run, then 2-cycle stall
        run(2);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        run(2);
        // Jump to 0x40 from 0x10
        step(0, 1, 32'h40, 0, 0, 0, 0, 0);
        run(2);
        // Jump together with stall: held, then taken when stall drops
        step(0, 1, 32'h80, 1, 0, 0, 0, 0);
        step(0, 1, 32'h80, 1, 0, 0, 0, 0);
        step(0, 1, 32'h80, 0, 0, 0, 0, 0);
        // Run to 0x20 and halt 5 cycles
        step(0, 1, 32'h18, 0, 0, 0, 0, 0);
        run(2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
        run(3);
        // PC wrap across 2^32
        step(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
        run(4);

        // Random mix
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 4095));
            step(r == 0, $urandom_range(0, 99) < 12, ja,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1,
                 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
